ula_issue: RTL and testbench

Issue/writeback controller that drives the `ula` ALU from the instruction side. It accepts 32-bit instruction words over a valid/ready handshake and decodes them. It reads operands from an internal register file, presents `opcode`/`A`/`B` to the ALU, captures the ALU result and writes it back. It sits between instruction fetch and `ula`, and serialises one instruction every 4 cycles.

---
 rtl/ula_issue_pkg.sv | 39 +++
 rtl/ula_regfile.sv | 42 ++++
 rtl/ula_issue.sv | 131 +++++++++++++
 tb/tb_ula_issue.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ula_issue_pkg.sv
// ============================================================================
// ula_issue_pkg : opcodes, instruction fields, FSM states and decode helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package ula_issue_pkg;

  localparam logic [7:0] OP_LDI = 8'h01;
  localparam logic [7:0] OP_ADD = 8'h09;
  localparam logic [7:0] OP_SUB = 8'h0A;
  localparam logic [7:0] OP_AND = 8'h0B;
  localparam logic [7:0] OP_OR  = 8'h0C;

  localparam int INSTR_W = 32;
  localparam int OPC_LSB = 24;
  localparam int RD_LSB  = 20;
  localparam int RS1_LSB = 16;
  localparam int RS2_LSB = 12;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  function automatic logic is_alu_op(input logic [7:0] opc);
    return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR);
  endfunction

  function automatic logic is_legal(input logic [7:0] opc);
    return is_alu_op(opc) || (opc == OP_LDI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ula_regfile.sv
// ============================================================================
// ula_regfile : 2^RADDR_W x DATA_W registers, three async read ports, one write
// Rev 1.0
// ============================================================================
`default_nettype none

module ula_regfile #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RADDR_W-1:0] ra1,
  input  logic [RADDR_W-1:0] ra2,
  input  logic [RADDR_W-1:0] ra3,
  output logic [DATA_W-1:0]  rd1,
  output logic [DATA_W-1:0]  rd2,
  output logic [DATA_W-1:0]  rd3,
  input  logic               we,
  input  logic [RADDR_W-1:0] wa,
  input  logic [DATA_W-1:0]  wd
);

  localparam int DEPTH = 1 << RADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[wa] <= wd;
    end
  end

  assign rd1 = r_mem[ra1];
  assign rd2 = r_mem[ra2];
  assign rd3 = r_mem[ra3];

endmodule

`default_nettype wire

// File: rtl/ula_issue.sv
// ============================================================================
// ula_issue : serialised issue/writeback controller in front of the ula ALU
// Rev 1.0
// ============================================================================
`default_nettype none

module ula_issue
  import ula_issue_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        instr_data,
  output logic [7:0]         alu_opcode,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W-1:0]  alu_out,
  output logic               done,
  output logic               err,
  output logic [DATA_W-1:0]  res_data,
  input  logic [RADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [INSTR_W-1:0]  r_instr;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic [DATA_W-1:0]   r_res;

  logic [7:0]          w_opc;
  logic [RADDR_W-1:0]  w_rd;
  logic [RADDR_W-1:0]  w_rs1;
  logic [RADDR_W-1:0]  w_rs2;
  logic [15:0]         w_imm;
  logic [DATA_W-1:0]   w_imm_sext;
  logic [DATA_W-1:0]   w_rd1;
  logic [DATA_W-1:0]   w_rd2;
  logic                w_we;

  assign w_opc      = r_instr[OPC_LSB +: 8];
  assign w_rd       = r_instr[RD_LSB  +: RADDR_W];
  assign w_rs1      = r_instr[RS1_LSB +: RADDR_W];
  assign w_rs2      = r_instr[RS2_LSB +: RADDR_W];
  assign w_imm      = r_instr[IMM_LSB +: 16];
  assign w_imm_sext = {{(DATA_W-16){w_imm[15]}}, w_imm};

  ula_regfile #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W)
  ) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (w_rs1),
    .ra2 (w_rs2),
    .ra3 (dbg_addr),
    .rd1 (w_rd1),
    .rd2 (w_rd2),
    .rd3 (dbg_data),
    .we  (w_we),
    .wa  (w_rd),
    .wd  (r_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_instr <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (instr_valid) r_instr <= instr_data;
        S_READ: begin
          r_op_a <= w_rd1;
          r_op_b <= w_rd2;
        end
        S_EXEC: begin
          if (is_alu_op(w_opc))   r_res <= alu_out;
          else if (w_opc == OP_LDI) r_res <= w_imm_sext;
          else                    r_res <= '0;
        end
        default: ;
      endcase
    end
  end

  // Ports to the ALU are forced to zero outside EXEC so its output idles at 0.
  always_comb begin
    w_state_nxt = r_state;
    instr_ready = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    res_data    = '0;
    alu_opcode  = '0;
    alu_a       = '0;
    alu_b       = '0;
    w_we        = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) w_state_nxt = S_READ;
      end
      S_READ: w_state_nxt = S_EXEC;
      S_EXEC: begin
        alu_opcode  = w_opc;
        alu_a       = r_op_a;
        alu_b       = r_op_b;
        w_state_nxt = S_WB;
      end
      S_WB: begin
        done        = 1'b1;
        err         = ~is_legal(w_opc);
        res_data    = r_res;
        w_we        = is_legal(w_opc);
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ula_issue.sv
// ============================================================================
// tb_ula_issue : directed self-checking bench for ula_issue with an ALU model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ula_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [7:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        done;
  logic        err;
  logic [31:0] res_data;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;

  int total = 0;
  int bad   = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  ula_issue #(.DATA_W(32), .RADDR_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_out     (alu_out),
    .done        (done),
    .err         (err),
    .res_data    (res_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // Behavioural stand-in for the ula ALU
  always_comb begin
    alu_out = 32'h0;
    case (alu_opcode)
      8'h09: alu_out = alu_a + alu_b;
      8'h0A: alu_out = alu_a - alu_b;
      8'h0B: alu_out = alu_a & alu_b;
      8'h0C: alu_out = alu_a | alu_b;
      default: alu_out = 32'h0;
    endcase
  end

  always @(negedge clk) if (done) done_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic peek_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", {31'b0, instr_ready}, 32'h1);
  endtask

  // Issue one instruction from a negedge, then check every stage at later negedges.
  task automatic run(input string tag, input logic [31:0] instr, input logic [31:0] exp_res,
                     input logic exp_err, input logic do_alu, input logic [7:0] exp_op,
                     input logic [31:0] exp_a, input logic [31:0] exp_b);
    wait_ready();
    instr_valid = 1'b1;
    instr_data  = instr;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr_data  = $urandom;
    @(negedge clk);
    check({tag, "_rd_ready"}, {31'b0, instr_ready}, 32'h0);
    check({tag, "_rd_done"},  {31'b0, done}, 32'h0);
    @(negedge clk);
    check({tag, "_ex_done"},  {31'b0, done}, 32'h0);
    if (do_alu) begin
      check({tag, "_ex_opc"}, {24'b0, alu_opcode}, {24'b0, exp_op});
      check({tag, "_ex_a"},   alu_a, exp_a);
      check({tag, "_ex_b"},   alu_b, exp_b);
    end
    @(negedge clk);
    check({tag, "_wb_done"},  {31'b0, done}, 32'h1);
    check({tag, "_wb_err"},   {31'b0, err}, {31'b0, exp_err});
    check({tag, "_wb_res"},   res_data, exp_res);
    check({tag, "_wb_opc"},   {24'b0, alu_opcode}, 32'h0);
    @(negedge clk);
    check({tag, "_idle_ready"}, {31'b0, instr_ready}, 32'h1);
    check({tag, "_idle_done"},  {31'b0, done}, 32'h0);
  endtask

  initial begin
    logic [31:0] q [3];
    int acc [3];
    int idx;
    int cyc;
    int lowcnt;
    int seen0;

    rst = 1'b1;
    instr_valid = 1'b0;
    instr_data = 32'h0;
    dbg_addr = 4'h0;
    repeat (3) @(negedge clk);
    instr_valid = 1'b1;  // must be ignored while in reset
    @(negedge clk);
    instr_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    check("rst_ready", {31'b0, instr_ready}, 32'h1);
    check("rst_done",  {31'b0, done}, 32'h0);
    check("rst_err",   {31'b0, err}, 32'h0);
    check("rst_res",   res_data, 32'h0);
    check("rst_opc",   {24'b0, alu_opcode}, 32'h0);
    check("rst_a",     alu_a, 32'h0);
    for (int i = 0; i < 16; i++) peek_reg($sformatf("rst_r%0d", i), 4'(i), 32'h0);

    run("ldi1", 32'h01100005, 32'h00000005, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0);
    run("ldi2", 32'h0120FFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0);
    peek_reg("dbg_r1", 4'd1, 32'h00000005);
    peek_reg("dbg_r2", 4'd2, 32'hFFFFFFFF);

    run("add", 32'h09312000, 32'h00000004, 1'b0, 1'b1, 8'h09, 32'h5, 32'hFFFFFFFF);
    run("sub", 32'h0A412000, 32'h00000006, 1'b0, 1'b1, 8'h0A, 32'h5, 32'hFFFFFFFF);
    run("and", 32'h0B512000, 32'h00000005, 1'b0, 1'b1, 8'h0B, 32'h5, 32'hFFFFFFFF);
    run("or",  32'h0C621000, 32'hFFFFFFFF, 1'b0, 1'b1, 8'h0C, 32'hFFFFFFFF, 32'h5);
    peek_reg("dbg_r3", 4'd3, 32'h00000004);
    peek_reg("dbg_r4", 4'd4, 32'h00000006);
    peek_reg("dbg_r5", 4'd5, 32'h00000005);
    peek_reg("dbg_r6", 4'd6, 32'hFFFFFFFF);

    run("ill", 32'h0D112000, 32'h00000000, 1'b1, 1'b0, 8'h0, 32'h0, 32'h0);
    peek_reg("ill_r1", 4'd1, 32'h00000005);

    // Back-to-back: valid held high with three queued LDIs
    q[0] = 32'h01700001;
    q[1] = 32'h01800002;
    q[2] = 32'h01900003;
    idx = 0;
    cyc = 0;
    lowcnt = 0;
    instr_valid = 1'b1;
    instr_data  = q[0];
    while (idx < 3 && cyc < 40) begin
      if (instr_ready) begin
        acc[idx] = cyc;
        idx++;
        @(posedge clk);
        #1;
        if (idx < 3) instr_data = q[idx];
        else instr_valid = 1'b0;
      end else begin
        lowcnt++;
      end
      @(negedge clk);
      cyc++;
    end
    instr_valid = 1'b0;
    check("b2b_count", 32'(idx), 32'd3);
    if (idx == 3) begin
      check("b2b_gap1", 32'(acc[1] - acc[0]), 32'd4);
      check("b2b_gap2", 32'(acc[2] - acc[1]), 32'd4);
      check("b2b_low",  32'(lowcnt), 32'd6);
    end
    repeat (3) @(negedge clk);
    check("b2b_ready", {31'b0, instr_ready}, 32'h1);
    peek_reg("b2b_r7", 4'd7, 32'h1);
    peek_reg("b2b_r8", 4'd8, 32'h2);
    peek_reg("b2b_r9", 4'd9, 32'h3);

    // Reset asserted in the EXEC cycle of ADD r3
    wait_ready();
    seen0 = done_seen;
    instr_valid = 1'b1;
    instr_data  = 32'h09312000;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rx_exec_opc", {24'b0, alu_opcode}, 32'h09);
    rst = 1'b1;
    #1;
    check("rx_opc_in_rst", {24'b0, alu_opcode}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rx_no_done", 32'(done_seen - seen0), 32'd0);
    peek_reg("rx_r3", 4'd3, 32'h0);
    peek_reg("rx_r1", 4'd1, 32'h0);
    run("rx_ldi", 32'h01A08000, 32'hFFFF8000, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0);
    peek_reg("rx_r10", 4'd10, 32'hFFFF8000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
